// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - AES-128 constants, byte-level transforms and FSM state type
package aes_pkg;

  localparam int         NB = 4;
  localparam logic [3:0] NR = 4'd10;

  localparam logic [7:0] RCON [10] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

  typedef enum logic [1:0] {IDLE, KEYEXP, ROUND, DONE} aes_state_e;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16};

  localparam logic [7:0] INV_SBOX [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d};

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[b];
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    return INV_SBOX[b];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] mix_column(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  // Inverse = forward MixColumns after a {05,00,04,00} pre-multiply.
  function automatic logic [31:0] inv_mix_column(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3, u, v;
    {a0, a1, a2, a3} = c;
    u = xtime(xtime(a0 ^ a2));
    v = xtime(xtime(a1 ^ a3));
    return mix_column({a0 ^ u, a1 ^ v, a2 ^ u, a3 ^ v});
  endfunction

  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < NB; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < NB; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(4*((c+r)%4)+r) -: 8] = s[127-8*(4*c+r) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    for (int i = 0; i < 16; i++) o[8*i +: 8] = sbox(s[8*i +: 8]);
    return o;
  endfunction

  function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    for (int i = 0; i < 16; i++) o[8*i +: 8] = inv_sbox(s[8*i +: 8]);
    return o;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] o;
    for (int c = 0; c < NB; c++) o[32*c +: 32] = mix_column(s[32*c +: 32]);
    return o;
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] o;
    for (int c = 0; c < NB; c++) o[32*c +: 32] = inv_mix_column(s[32*c +: 32]);
    return o;
  endfunction

endpackage

// File: rtl/aes_key_expand.sv
// rtl/aes_key_expand.sv - one combinational AES-128 key-schedule step
module aes_key_expand
  import aes_pkg::*;
(
  input  logic [127:0] prev_key_i,
  input  logic [3:0]   rcon_idx_i,
  output logic [127:0] next_key_o
);

  logic [31:0] w0, w1, w2, w3, temp, n0, n1, n2, n3;

  assign {w0, w1, w2, w3} = prev_key_i;
  // RotWord folded into the byte order fed to SubWord
  assign temp = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])}
              ^ {RCON[rcon_idx_i], 24'h000000};
  assign n0 = w0 ^ temp;
  assign n1 = w1 ^ n0;
  assign n2 = w2 ^ n1;
  assign n3 = w3 ^ n2;
  assign next_key_o = {n0, n1, n2, n3};

endmodule

// File: rtl/aes128_core.sv
// rtl/aes128_core.sv - iterative AES-128 encrypt/decrypt core with start/ready handshake
module aes128_core
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start_in,
  input  logic         en_or_de,
  input  logic [127:0] key_in,
  input  logic [127:0] plain_text_in,
  output logic [127:0] cipher_text_out,
  output logic         cipher_text_ready_out
);

  aes_state_e   state_q, state_d;
  logic [127:0] rk_q [11];
  logic [127:0] blk_q, st_q, out_q, out_d;
  logic [127:0] next_rk, rnd_t, round_out;
  logic [3:0]   cnt_q;
  logic         enc_q, ready_q, ready_d, block_q, accept;

  // DONE accepts only once the result is visible; block_q stops a held start re-triggering.
  assign accept = start_in && !block_q &&
                  (state_q == IDLE || (state_q == DONE && ready_q));

  aes_key_expand u_key_expand (
    .prev_key_i (rk_q[cnt_q]),
    .rcon_idx_i (cnt_q),
    .next_key_o (next_rk)
  );

  always_comb begin
    rnd_t     = '0;
    round_out = '0;
    if (enc_q) begin
      rnd_t = shift_rows(sub_bytes(st_q));
      if (cnt_q != NR) rnd_t = mix_columns(rnd_t);
      round_out = rnd_t ^ rk_q[cnt_q];
    end else begin
      rnd_t     = inv_sub_bytes(inv_shift_rows(st_q)) ^ rk_q[NR - cnt_q];
      round_out = (cnt_q != NR) ? inv_mix_columns(rnd_t) : rnd_t;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      ready_q <= 1'b0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      out_q   <= out_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = KEYEXP;
      KEYEXP:  if (cnt_q == NR - 4'd1) state_d = ROUND;
      ROUND:   if (cnt_q == NR) state_d = DONE;
      DONE:    if (accept) state_d = KEYEXP;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ready_d = ready_q;
    out_d   = out_q;
    if (accept) begin
      ready_d = 1'b0;
    end else if (state_q == DONE) begin
      ready_d = 1'b1;
      out_d   = st_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < 11; i++) rk_q[i] <= '0;
      blk_q   <= '0;
      st_q    <= '0;
      cnt_q   <= '0;
      enc_q   <= 1'b0;
      block_q <= 1'b0;
    end else begin
      if (accept)         block_q <= 1'b1;
      else if (!start_in) block_q <= 1'b0;

      if (accept) begin
        rk_q[0] <= key_in;
        blk_q   <= plain_text_in;
        enc_q   <= en_or_de;
        cnt_q   <= '0;
      end else begin
        case (state_q)
          KEYEXP: begin
            rk_q[cnt_q + 4'd1] <= next_rk;
            if (cnt_q == NR - 4'd1) begin
              st_q  <= blk_q ^ (enc_q ? rk_q[0] : next_rk);
              cnt_q <= 4'd1;
            end else begin
              cnt_q <= cnt_q + 4'd1;
            end
          end
          ROUND: begin
            st_q  <= round_out;
            cnt_q <= cnt_q + 4'd1;
          end
          default: ;
        endcase
      end
    end
  end

  assign cipher_text_out       = out_q;
  assign cipher_text_ready_out = ready_q;

endmodule

// File: tb/tb_aes128_core.sv
// tb/tb_aes128_core.sv - self-checking bench for aes128_core against a GF(2^8) AES model
module tb_aes128_core;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         start_in = 1'b0;
  logic         en_or_de = 1'b0;
  logic [127:0] key_in = '0;
  logic [127:0] plain_text_in = '0;
  logic [127:0] cipher_text_out;
  logic         cipher_text_ready_out;

  localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] P2 = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] C2 = 128'h3925841d02dc09fbdc118597196a0b32;

  always #5 clk = ~clk;

  aes128_core dut (
    .clk                   (clk),
    .reset_n               (reset_n),
    .start_in              (start_in),
    .en_or_de              (en_or_de),
    .key_in                (key_in),
    .plain_text_in         (plain_text_in),
    .cipher_text_out       (cipher_text_out),
    .cipher_text_ready_out (cipher_text_ready_out)
  );

  int checks = 0;
  int errors = 0;
  logic [7:0] sb [256];
  logic [7:0] isb [256];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %h required %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa, bb;
    p = 8'h00; aa = a; bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
      bb = bb >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    logic [15:0] t;
    t = {x, x} << n;
    return t[15:8];
  endfunction

  // S-box from its definition: multiplicative inverse then affine map.
  function automatic logic [7:0] sbox_calc(input logic [7:0] x);
    logic [7:0] inv;
    inv = 8'h01;
    for (int i = 0; i < 254; i++) inv = gmul(inv, x);
    if (x == 8'h00) inv = 8'h00;
    return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
  endfunction

  function automatic logic [127:0] aes_model(input logic [127:0] key, input logic [127:0] blk, input bit enc);
    logic [31:0] w [44];
    logic [7:0]  rk [11][16];
    logic [7:0]  s [16];
    logic [7:0]  t [16];
    logic [7:0]  m [4];
    logic [7:0]  rc, acc;
    logic [31:0] tmp;
    logic [127:0] res;
    int          kr;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {tmp[23:0], tmp[31:24]};
        tmp = {sb[tmp[31:24]], sb[tmp[23:16]], sb[tmp[15:8]], sb[tmp[7:0]]} ^ {rc, 24'h0};
        rc  = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int r = 0; r < 11; r++)
      for (int j = 0; j < 16; j++) rk[r][j] = w[4*r + j/4][31-8*(j%4) -: 8];
    if (enc) m = '{8'h02, 8'h03, 8'h01, 8'h01};
    else     m = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
    kr = enc ? 0 : 10;
    for (int j = 0; j < 16; j++) s[j] = blk[127-8*j -: 8] ^ rk[kr][j];
    for (int step = 0; step < 10; step++) begin
      if (enc) begin
        for (int c = 0; c < 4; c++)
          for (int r = 0; r < 4; r++) t[r+4*c] = sb[s[r+4*((c+r)%4)]];
        s = t;
      end else begin
        for (int c = 0; c < 4; c++)
          for (int r = 0; r < 4; r++) t[r+4*((c+r)%4)] = isb[s[r+4*c]];
        for (int j = 0; j < 16; j++) s[j] = t[j] ^ rk[9-step][j];
      end
      if (step < 9) begin
        for (int c = 0; c < 4; c++)
          for (int r = 0; r < 4; r++) begin
            acc = 8'h00;
            for (int k = 0; k < 4; k++) acc = acc ^ gmul(m[(k-r+4)%4], s[4*c+k]);
            t[4*c+r] = acc;
          end
        s = t;
      end
      if (enc) for (int j = 0; j < 16; j++) s[j] = s[j] ^ rk[step+1][j];
    end
    for (int j = 0; j < 16; j++) res[127-8*j -: 8] = s[j];
    return res;
  endfunction

  // Transaction-level expectation: accepted start -> result 21 edges later.
  bit           m_ready = 1'b0;
  bit           m_busy = 1'b0;
  bit           m_armed = 1'b1;
  logic [127:0] m_out = '0;
  logic [127:0] m_pend = '0;
  int           m_cnt = 0;

  always @(posedge clk) begin
    if (!reset_n) begin
      m_ready <= 1'b0;
      m_out   <= '0;
      m_busy  <= 1'b0;
      m_armed <= 1'b1;
    end else begin
      if (!start_in) m_armed <= 1'b1;
      if (start_in && m_armed && !m_busy) begin
        m_armed <= 1'b0;
        m_busy  <= 1'b1;
        m_ready <= 1'b0;
        m_cnt   <= 21;
        m_pend  <= aes_model(key_in, plain_text_in, en_or_de);
      end else if (m_busy) begin
        m_cnt <= m_cnt - 1;
        if (m_cnt == 1) begin
          m_ready <= 1'b1;
          m_out   <= m_pend;
          m_busy  <= 1'b0;
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("cyc_ready", 128'(cipher_text_ready_out), 128'(m_ready));
    chk("cyc_out", cipher_text_out, m_out);
  end

  task automatic wait_ready(output int n);
    n = 0;
    while (cipher_text_ready_out !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic run_op(input logic [127:0] k, input logic [127:0] b, input bit e,
                        input logic [127:0] exp, input string nm);
    int n;
    @(negedge clk);
    key_in = k; plain_text_in = b; en_or_de = e; start_in = 1'b1;
    @(negedge clk);
    start_in = 1'b0;
    chk({nm, "_ready_drop"}, 128'(cipher_text_ready_out), 128'd0);
    wait_ready(n);
    chk({nm, "_latency"}, 128'(n), 128'd21);
    chk(nm, cipher_text_out, exp);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [127:0] rk, rb, rexp;
    int n;
    for (int x = 0; x < 256; x++) begin
      sb[x] = sbox_calc(8'(x));
      isb[sb[x]] = 8'(x);
    end
    chk("model_c1_enc", aes_model(K1, P1, 1'b1), C1);
    chk("model_c1_dec", aes_model(K1, C1, 1'b0), P1);
    chk("model_b_enc", aes_model(K2, P2, 1'b1), C2);
    chk("model_b_dec", aes_model(K2, C2, 1'b0), P2);

    repeat (3) @(negedge clk);
    chk("reset_ready", 128'(cipher_text_ready_out), 128'd0);
    chk("reset_out", cipher_text_out, 128'd0);
    reset_n = 1'b1;

    run_op(K1, P1, 1'b1, C1, "c1_enc");
    run_op(K1, C1, 1'b0, P1, "c1_dec");
    run_op(K2, P2, 1'b1, C2, "b_enc");
    run_op(K2, C2, 1'b0, P2, "b_dec");

    @(negedge clk);
    key_in = K1; plain_text_in = P1; en_or_de = 1'b1; start_in = 1'b1;
    @(negedge clk);
    start_in = 1'b0;
    repeat (11) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    chk("midop_reset_ready", 128'(cipher_text_ready_out), 128'd0);
    chk("midop_reset_out", cipher_text_out, 128'd0);
    reset_n = 1'b1;
    run_op(K2, P2, 1'b1, C2, "after_reset");

    @(negedge clk);
    key_in = K2; plain_text_in = P2; en_or_de = 1'b1; start_in = 1'b1;
    @(negedge clk);
    start_in = 1'b0;
    repeat (4) @(negedge clk);
    key_in = K1; plain_text_in = C1; en_or_de = 1'b0; start_in = 1'b1;
    @(negedge clk);
    start_in = 1'b0;
    wait_ready(n);
    chk("busy_start_ignored", cipher_text_out, C2);

    @(negedge clk);
    key_in = K1; plain_text_in = P1; en_or_de = 1'b1; start_in = 1'b1;
    repeat (40) @(negedge clk);
    chk("held_start_ready", 128'(cipher_text_ready_out), 128'd1);
    chk("held_start_out", cipher_text_out, C1);
    start_in = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      rk   = {$urandom, $urandom, $urandom, $urandom};
      rb   = {$urandom, $urandom, $urandom, $urandom};
      rexp = aes_model(rk, rb, i[0]);
      run_op(rk, rb, i[0], rexp, "rand");
      run_op(rk, rexp, !i[0], rb, "rand_inverse");
    end

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/aes128_core.md
Name: aes128_core

Overview:
- Iterative AES-128 block cipher core (FIPS-197); one 128-bit block per operation.
- Encrypts or decrypts depending on the en_or_de input.
- Sits behind a simple start/ready handshake.
- Used standalone by crypto datapaths; the same instance serves both directions.

Parameters:
- None. Key size (128), rounds (10) and block width (128) are fixed constants in the package.

Ports:
- clk  input  1  rising-edge clock; single clock domain
- reset_n  input  1  synchronous, active-low reset
- start_in  input  1  one-cycle pulse; begins an operation when the core is idle
- en_or_de  input  1  1 = encrypt, 0 = decrypt; sampled with start_in
- key_in  input  128  cipher key; sampled with start_in; bit 127 = first key byte
- plain_text_in  input  128  input block: plaintext when encrypting, ciphertext when decrypting; sampled with start_in
- cipher_text_out  output  128  result block: ciphertext when encrypting, plaintext when decrypting
- cipher_text_ready_out  output  1  high while cipher_text_out holds a valid result

Behaviour:
- Interface decision: one clock (clk); reset is synchronous and active-low (reset_n).
- Reset (reset_n=0 at a rising edge):
  - FSM goes to IDLE; all state and round-key registers clear.
  - cipher_text_out = 0, cipher_text_ready_out = 0.
  - Reset mid-operation aborts the operation; no result is produced.
- Byte order: state byte 0 = bits [127:120]; column-major as in FIPS-197.
- FSM states: IDLE, KEYEXP, ROUND, DONE.
- IDLE:
  - On start_in=1, latch key_in, plain_text_in and en_or_de.
  - Store the key as round key 0, clear cipher_text_ready_out, go to KEYEXP.
- KEYEXP (10 cycles):
  - Compute round keys 1..10 one per cycle (RotWord, SubWord, Rcon 01,02,04,08,10,20,40,80,1b,36).
  - Store all 11 round keys in a register array.
  - On the last cycle, load state = block XOR rk0 (encrypt) or block XOR rk10 (decrypt). Go to ROUND.
- ROUND (10 cycles, round counter r = 1..10):
  - Encrypt: SubBytes, ShiftRows, MixColumns (skipped when r=10), XOR rk[r].
  - Decrypt: InvShiftRows, InvSubBytes, XOR rk[10-r], InvMixColumns (skipped when r=10).
  - After r=10, go to DONE.
- DONE:
  - Drive cipher_text_out = state and cipher_text_ready_out = 1.
  - Hold both until the next accepted start_in, which clears ready and restarts.
- Latency: cipher_text_ready_out rises on the 21st rising edge after the edge that sampled start_in.
- Back-to-back: a new start_in is accepted from DONE (as from IDLE).
- start_in asserted in KEYEXP or ROUND is ignored; input changes during an operation have no effect.
- start_in held high for several cycles: only the first edge in IDLE/DONE starts an operation. No re-trigger while start stays high after completion unless it is deasserted first.
- Same key and block with en_or_de toggled: the operations must be exact inverses.

Decomposition:
- Package aes_pkg:
  - Constants: NB=4, NR=10, RCON table.
  - Functions: sbox, inv_sbox (256-entry lookups), xtime, mix_column, inv_mix_column, shift_rows, inv_shift_rows.
  - FSM state typedef.
- One sub-module, aes_key_expand: combinational next-round-key from the previous round key and Rcon index.
- Core FSM and datapath remain in aes128_core.

Test Plan:
- Encrypt FIPS-197 C.1: key 000102030405060708090a0b0c0d0e0f, in 00112233445566778899aabbccddeeff, en_or_de=1 -> out 69c4e0d86a7b0430d8cdb78070b4c55a, ready after exactly 21 cycles.
- Decrypt same key: in 69c4e0d86a7b0430d8cdb78070b4c55a, en_or_de=0 -> out 00112233445566778899aabbccddeeff.
- Appendix B: key 2b7e151628aed2a6abf7158809cf4f3c, in 3243f6a8885a308d313198a2e0370734, encrypt -> 3925841d02dc09fbdc118597196a0b32; decrypt of that result -> original block.
- Reset mid-operation: assert reset_n=0 at cycle 12 -> outputs 0, ready 0. A fresh start then completes correctly in 21 cycles.
- Start while busy: pulse start_in with different key/data at cycle 5 -> ignored; result equals the first operation's vector.
- Back-to-back: start from DONE with a new vector -> ready drops the next cycle; the new correct result appears 21 cycles later. Covers random vectors checked against a reference model, both directions.
